// File: rtl/alu_operand_loader_pkg.sv
// Shared constants for the ALU operand loader: FSM states, reported state codes,
// uio bit positions and the fixed uio output-enable pattern.
package alu_loader_pkg;

    localparam int UIO_STB   = 0;
    localparam int UIO_ABORT = 1;
    localparam int UIO_READY = 4;
    localparam int UIO_BUSY  = 5;

    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef enum logic [1:0] {
        CODE_A    = 2'd0,
        CODE_B    = 2'd1,
        CODE_OP   = 2'd2,
        CODE_EXEC = 2'd3
    } state_code_e;

    // S_DONE is reported as code 0; the host tells it apart from S_A by ready.
    function automatic state_code_e state_code(input logic [2:0] s);
        case (s)
            S_B:     return CODE_B;
            S_OP:    return CODE_OP;
            S_EXEC:  return CODE_EXEC;
            default: return CODE_A;
        endcase
    endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Parallel operand/result bus between the loader (master) and the 8-bit ALU (slave).
interface alu_operand_loader_if;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_sel;
    logic [7:0] alu_result;

    modport master (output alu_a, output alu_b, output alu_sel, input alu_result);
    modport slave  (input alu_a, input alu_b, input alu_sel, output alu_result);
endinterface

// File: rtl/alu_operand_loader_sync_edge.sv
// Host strobe/abort conditioning: optional 2-flop synchronizer (ALU_LOADER_SYNC_EN)
// followed by a registered rising-edge detector on the strobe.
module strobe_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_in,
    input  logic abort_in,
    output logic stb,
    output logic abort
);
    logic strobe_s;
    logic strobe_q, strobe_d;

`ifdef ALU_LOADER_SYNC_EN
    logic [1:0] meta_q, meta_d;
    logic [1:0] sync_q, sync_d;

    always_comb begin
        meta_d = {abort_in, strobe_in};
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign strobe_s = sync_q[0];
    assign abort    = sync_q[1];
`else
    assign strobe_s = strobe_in;
    assign abort    = abort_in;
`endif

    // History updates regardless of enable so a strobe held across re-enable is not an edge.
    always_comb strobe_d = strobe_s;

    always_ff @(posedge clk) begin
        if (!rst_n) strobe_q <= 1'b0;
        else        strobe_q <= strobe_d;
    end

    assign stb = strobe_s & ~strobe_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Captures A, B and selector over three host strobes, drives them to the ALU and
// registers its result. Optional input synchronizer: define ALU_LOADER_SYNC_EN.
module alu_operand_loader
    import alu_loader_pkg::*;
#(
    parameter logic [7:0] RES_RESET = 8'h00
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic [7:0]                  ui_in,
    input  logic [7:0]                  uio_in,
    output logic [7:0]                  uio_out,
    output logic [7:0]                  uio_oe,
    output logic [7:0]                  uo_out,
    alu_operand_loader_if.master        alu_bus
);
    logic stb, abort;
    logic [5:0] unused_uio;

    logic [2:0] state_q, state_d;
    logic [7:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0] sel_q, sel_d;
    logic       ready_q, ready_d;
    logic       busy;

    assign unused_uio = uio_in[7:2];

    strobe_sync_edge u_sync_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .strobe_in (uio_in[UIO_STB]),
        .abort_in  (uio_in[UIO_ABORT]),
        .stb       (stb),
        .abort     (abort)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        res_d   = res_q;
        ready_d = ready_q;
        if (ena) begin
            // Abort outranks a coincident strobe; operands are deliberately kept.
            if (abort) begin
                state_d = S_A;
                ready_d = 1'b0;
                res_d   = RES_RESET;
            end else begin
                case (state_q)
                    S_A: if (stb) begin
                        a_d     = ui_in;
                        state_d = S_B;
                    end
                    S_B: if (stb) begin
                        b_d     = ui_in;
                        state_d = S_OP;
                    end
                    S_OP: if (stb) begin
                        sel_d   = ui_in[1:0];
                        state_d = S_EXEC;
                    end
                    S_EXEC: begin
                        res_d   = alu_bus.alu_result;
                        ready_d = 1'b1;
                        state_d = S_DONE;
                    end
                    S_DONE: if (stb) begin
                        a_d     = ui_in;
                        ready_d = 1'b0;
                        state_d = S_B;
                    end
                    default: state_d = S_A;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            res_q   <= RES_RESET;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            ready_q <= ready_d;
        end
    end

    assign busy = (state_q == S_B) || (state_q == S_OP) || (state_q == S_EXEC);

    always_comb begin
        uio_out            = '0;
        uio_out[7:6]       = state_code(state_q);
        uio_out[UIO_BUSY]  = busy;
        uio_out[UIO_READY] = ready_q;
    end

    assign uio_oe          = UIO_OE_VAL;
    assign uo_out          = res_q;
    assign alu_bus.alu_a   = a_q;
    assign alu_bus.alu_b   = b_q;
    assign alu_bus.alu_sel = sel_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader: vector table of full transactions plus
// hand sequences for abort, held strobe, enable gating, latency and reset.
module tb_alu_operand_loader;

`ifdef ALU_LOADER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    int n_cmp = 0;
    int n_err = 0;

    alu_operand_loader_if alu_bus ();

    // ALU stand-in: add for sel 00, subtract for sel 01.
    always_comb begin
        case (alu_bus.alu_sel)
            2'd0:    alu_bus.alu_result = alu_bus.alu_a + alu_bus.alu_b;
            2'd1:    alu_bus.alu_result = alu_bus.alu_a - alu_bus.alu_b;
            2'd2:    alu_bus.alu_result = alu_bus.alu_a & alu_bus.alu_b;
            default: alu_bus.alu_result = alu_bus.alu_a | alu_bus.alu_b;
        endcase
    end

    alu_operand_loader #(.RES_RESET(8'h00)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .uo_out  (uo_out),
        .alu_bus (alu_bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] sel;
        logic [7:0] res;
    } vec_t;

    vec_t vtab [5];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] v);
        @(negedge clk);
        ui_in     = v;
        uio_in[0] = 1'b1;
        @(negedge clk);
        uio_in[0] = 1'b0;
        repeat (LAT + 1) @(negedge clk);
    endtask

    task automatic abort_pulse();
        @(negedge clk);
        uio_in[1] = 1'b1;
        @(negedge clk);
        uio_in[1] = 1'b0;
        repeat (LAT) @(negedge clk);
    endtask

    initial begin
        vtab[0] = '{a: 8'h12, b: 8'h34, sel: 2'd0, res: 8'h46};
        vtab[1] = '{a: 8'h10, b: 8'h20, sel: 2'd1, res: 8'hF0};
        vtab[2] = '{a: 8'hFF, b: 8'h01, sel: 2'd0, res: 8'h00};
        vtab[3] = '{a: 8'h80, b: 8'h7F, sel: 2'd1, res: 8'h01};
        vtab[4] = '{a: 8'h00, b: 8'h01, sel: 2'd1, res: 8'hFF};

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_uo_out", uo_out, 8'h00);
        chk("rst_uio_out", uio_out, 8'h00);
        chk("rst_uio_oe", uio_oe, 8'hF0);
        chk("rst_alu_a", alu_bus.alu_a, 8'h00);
        chk("rst_alu_b", alu_bus.alu_b, 8'h00);
        chk("rst_alu_sel", {6'd0, alu_bus.alu_sel}, 8'h00);

        for (int i = 0; i < 5; i++) begin
            pulse(vtab[i].a);
            pulse(vtab[i].b);
            pulse({6'd0, vtab[i].sel});
            chk($sformatf("vec%0d_uo_out", i), uo_out, vtab[i].res);
            chk($sformatf("vec%0d_uio_out", i), uio_out, 8'h10);
            chk($sformatf("vec%0d_alu_a", i), alu_bus.alu_a, vtab[i].a);
            chk($sformatf("vec%0d_alu_b", i), alu_bus.alu_b, vtab[i].b);
        end

        // Back-to-back: new A in S_DONE drops ready, result holds until next exec.
        pulse(8'h05);
        chk("b2b_uio_out", uio_out, 8'h60);
        chk("b2b_uo_hold", uo_out, 8'hFF);
        pulse(8'h03);
        pulse(8'h00);
        chk("b2b_uo_out", uo_out, 8'h08);
        chk("b2b_ready", uio_out, 8'h10);

        // Abort after B capture.
        pulse(8'h11);
        pulse(8'h22);
        chk("abort_pre_state", uio_out, 8'h80 | 8'h20);
        abort_pulse();
        chk("abort_uio_out", uio_out, 8'h00);
        chk("abort_uo_out", uo_out, 8'h00);
        chk("abort_keeps_a", alu_bus.alu_a, 8'h11);
        pulse(8'h30);
        pulse(8'h0C);
        pulse(8'h01);
        chk("post_abort_uo", uo_out, 8'h24);
        chk("post_abort_uio", uio_out, 8'h10);

        // Strobe held high for 10 cycles: one capture only.
        abort_pulse();
        @(negedge clk);
        ui_in     = 8'h77;
        uio_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        ui_in = 8'h99;
        repeat (5) @(negedge clk);
        uio_in[0] = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        chk("held_state", uio_out, 8'h60);
        chk("held_alu_a", alu_bus.alu_a, 8'h77);
        chk("held_alu_b", alu_bus.alu_b, 8'h0C);

        // Strobe and abort together: abort wins, no capture.
        abort_pulse();
        @(negedge clk);
        ui_in  = 8'h3C;
        uio_in = 8'h03;
        @(negedge clk);
        uio_in = 8'h00;
        repeat (LAT + 1) @(negedge clk);
        chk("stb_abort_state", uio_out, 8'h00);
        chk("stb_abort_alu_a", alu_bus.alu_a, 8'h77);

        // Capture latency and exec timing.
        @(negedge clk);
        ui_in     = 8'h5A;
        uio_in[0] = 1'b1;
        @(negedge clk);
        uio_in[0] = 1'b0;
        chk("lat_early", uio_out, (LAT == 0) ? 8'h60 : 8'h00);
        repeat (LAT) @(negedge clk);
        chk("lat_cap_state", uio_out, 8'h60);
        chk("lat_cap_a", alu_bus.alu_a, 8'h5A);
        pulse(8'h10);
        @(negedge clk);
        ui_in     = 8'h01;
        uio_in[0] = 1'b1;
        @(negedge clk);
        uio_in[0] = 1'b0;
        repeat (LAT) @(negedge clk);
        chk("exec_state", uio_out, 8'hE0);
        @(negedge clk);
        chk("exec_ready", uio_out, 8'h10);
        chk("exec_uo_out", uo_out, 8'h4A);

        // Enable gating in S_OP, then re-enable with strobe held high.
        abort_pulse();
        pulse(8'h21);
        pulse(8'h43);
        chk("ena_pre_state", uio_out, 8'hA0);
        ena = 1'b0;
        pulse(8'h02);
        pulse(8'h03);
        chk("ena_off_state", uio_out, 8'hA0);
        chk("ena_off_sel", {6'd0, alu_bus.alu_sel}, 8'h01);
        @(negedge clk);
        uio_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        ena = 1'b1;
        repeat (4) @(negedge clk);
        chk("ena_no_spurious", uio_out, 8'hA0);
        uio_in[0] = 1'b0;
        pulse(8'h01);
        chk("ena_resume_uo", uo_out, 8'hDE);
        chk("ena_resume_uio", uio_out, 8'h10);

        // Reset mid-transaction.
        pulse(8'h99);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_uio", uio_out, 8'h00);
        chk("mid_rst_uo", uo_out, 8'h00);
        chk("mid_rst_a", alu_bus.alu_a, 8'h00);
        chk("mid_rst_b", alu_bus.alu_b, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
